// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with posted one-entry write buffer
//
// Purpose: services the single-cycle core's memory port. Reads are
// combinational; writes are posted into a one-entry buffer that commits to the
// array on the following edge. A read of the buffered word is forwarded from
// the buffer. Out-of-range accesses set a sticky error flag and capture the
// first offending byte address.
//
// Ports:
//   clk, rst_n             single clock, synchronous active-low reset
//   mem_ce, mem_we         access request / write request
//   mem_raddr, mem_waddr   read / write byte addresses
//   mem_wdata              64-bit write data
//   mem_rdata              combinational read data
//   err_o, err_addr_o      sticky out-of-range flag and first offending address
//   rd_cnt_o, wr_cnt_o     in-range read/write counters (DMEM_STATS_EN only)
//
// Optional feature macro: DMEM_STATS_EN
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [63:0] mem_raddr,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        err_o,
`ifdef DMEM_STATS_EN
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
`endif
  output logic [63:0] err_addr_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [63:0] mem_q [DEPTH];

  logic                  wb_valid_q, wb_valid_d;
  logic [DEPTH_LOG2-1:0] wb_idx_q, wb_idx_d;
  logic [63:0]           wb_data_q, wb_data_d;
  logic                  err_q, err_d;
  logic [63:0]           err_addr_q, err_addr_d;

  logic [63:0]           roff, woff;
  logic                  r_in, w_in;
  logic [DEPTH_LOG2-1:0] ridx, widx;
  logic                  wr_go, r_bad, w_bad;

  // Word offset below 2^DEPTH_LOG2 is the same as byte offset below the
  // window size; the lower bound guards against wrap-around of the subtract.
  assign roff = mem_raddr - BASE_ADDR;
  assign woff = mem_waddr - BASE_ADDR;
  assign r_in = (mem_raddr >= BASE_ADDR) && (((roff >> 3) >> DEPTH_LOG2) == 64'd0);
  assign w_in = (mem_waddr >= BASE_ADDR) && (((woff >> 3) >> DEPTH_LOG2) == 64'd0);
  assign ridx = roff[DEPTH_LOG2+2:3];
  assign widx = woff[DEPTH_LOG2+2:3];

  assign wr_go = mem_ce && mem_we && w_in;
  assign r_bad = mem_ce && !r_in;
  assign w_bad = mem_ce && mem_we && !w_in;

  always_comb begin
    wb_valid_d = wr_go;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (wr_go) begin
      wb_idx_d  = widx;
      wb_data_d = mem_wdata;
    end
    // Only the first bad access is captured; write address wins a tie.
    if (!err_q && (r_bad || w_bad)) begin
      err_d      = 1'b1;
      err_addr_d = w_bad ? mem_waddr : mem_raddr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Array is not reset; a write still pending when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wb_valid_q) begin
      mem_q[wb_idx_q] <= wb_data_q;
    end
  end

  // A same-cycle write is not yet in the buffer, so the read sees the old word.
  always_comb begin
    mem_rdata = 64'd0;
    if (rst_n && mem_ce && r_in) begin
      if (wb_valid_q && (wb_idx_q == ridx)) begin
        mem_rdata = wb_data_q;
      end else begin
        mem_rdata = mem_q[ridx];
      end
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (mem_ce && !mem_we && r_in) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_go)                     wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_ce;
  logic        mem_we;
  logic [63:0] mem_raddr;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        err_o;
  logic [63:0] err_addr_o;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_o;
  logic [31:0] wr_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] A00  = 64'h8000_0000;
  localparam logic [63:0] A08  = 64'h8000_0008;
  localparam logic [63:0] A10  = 64'h8000_0010;
  localparam logic [63:0] A18  = 64'h8000_0018;
  localparam logic [63:0] A20  = 64'h8000_0020;
  localparam logic [63:0] ALST = 64'h8000_7FF8;
  localparam logic [63:0] AEND = 64'h8000_8000;
  localparam logic [63:0] ALOW = 64'h7FFF_FFF8;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;

  dmem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .err_o      (err_o),
`ifdef DMEM_STATS_EN
    .rd_cnt_o   (rd_cnt_o),
    .wr_cnt_o   (wr_cnt_o),
`endif
    .err_addr_o (err_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic step(input logic rst, input logic ce, input logic we,
                      input logic [63:0] ra, input logic [63:0] wa,
                      input logic [63:0] wd);
    @(posedge clk);
    #1;
    rst_n     = rst;
    mem_ce    = ce;
    mem_we    = we;
    mem_raddr = ra;
    mem_waddr = wa;
    mem_wdata = wd;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
    mem_raddr = '0; mem_waddr = '0; mem_wdata = '0;

    // Reset
    step(1'b0, 1'b1, 1'b0, A10, A10, 64'd0);
    chk("rst_rdata", mem_rdata, 64'd0);
    step(1'b0, 1'b0, 1'b0, A10, A10, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_err_addr", err_addr_o, 64'd0);

    // Write then read: forwarded, then from array
    step(1'b1, 1'b1, 1'b1, A10, A10, DEAD);
    step(1'b1, 1'b1, 1'b0, A10, A10, 64'd0);
    chk("fwd_read", mem_rdata, DEAD);
    step(1'b1, 1'b0, 1'b0, A10, A10, 64'd0);
    chk("ce0_read", mem_rdata, 64'd0);
    step(1'b1, 1'b1, 1'b0, A10, A10, 64'd0);
    chk("array_read", mem_rdata, DEAD);

    // Preload word 0 and 0x20
    step(1'b1, 1'b1, 1'b1, A10, A00, 64'h11);
    step(1'b1, 1'b1, 1'b1, A10, A20, 64'd1);
    step(1'b1, 1'b0, 1'b0, A10, A10, 64'd0);
    step(1'b1, 1'b0, 1'b0, A10, A10, 64'd0);

    // Same-cycle read/write returns the old value
    step(1'b1, 1'b1, 1'b1, A20, A20, 64'd2);
    chk("same_cycle_old", mem_rdata, 64'd1);
    step(1'b1, 1'b1, 1'b0, A20, A20, 64'd0);
    chk("same_cycle_new", mem_rdata, 64'd2);

    // Back-to-back writes to the same word
    step(1'b1, 1'b1, 1'b1, A10, A08, 64'd5);
    step(1'b1, 1'b1, 1'b1, A08, A08, 64'd6);
    chk("b2b_first_fwd", mem_rdata, 64'd5);
    step(1'b1, 1'b1, 1'b0, A08, A08, 64'd0);
    chk("b2b_newer", mem_rdata, 64'd6);
    step(1'b1, 1'b0, 1'b0, A08, A08, 64'd0);
    step(1'b1, 1'b0, 1'b0, A08, A08, 64'd0);
    step(1'b1, 1'b1, 1'b0, A08, A08, 64'd0);
    chk("b2b_settled", mem_rdata, 64'd6);

    // Last word of the window
    step(1'b1, 1'b1, 1'b1, ALST, ALST, 64'h77);
    step(1'b1, 1'b1, 1'b0, ALST, ALST, 64'd0);
    chk("last_word", mem_rdata, 64'h77);
    chk("last_word_err", {63'd0, err_o}, 64'd0);

    // Out of range below the window
    step(1'b1, 1'b1, 1'b0, ALOW, A10, 64'd0);
    chk("oor_rdata", mem_rdata, 64'd0);
    step(1'b1, 1'b0, 1'b0, A10, A10, 64'd0);
    chk("oor_err", {63'd0, err_o}, 64'd1);
    chk("oor_err_addr", err_addr_o, ALOW);

    // Write one past the end: dropped, error address unchanged
    step(1'b1, 1'b1, 1'b1, A10, AEND, 64'hBAD);
    step(1'b1, 1'b1, 1'b0, AEND, A10, 64'd0);
    chk("end_rdata", mem_rdata, 64'd0);
    step(1'b1, 1'b1, 1'b0, A00, A10, 64'd0);
    chk("end_dropped", mem_rdata, 64'h11);
    chk("end_err_addr", err_addr_o, ALOW);

    // Reset with a pending write
    step(1'b1, 1'b1, 1'b1, A10, A00, 64'd9);
    step(1'b0, 1'b1, 1'b0, A00, A10, 64'd0);
    chk("rst_mid_rdata", mem_rdata, 64'd0);
    step(1'b1, 1'b1, 1'b0, A00, A10, 64'd0);
    chk("rst_mid_err", {63'd0, err_o}, 64'd0);
    chk("rst_mid_err_addr", err_addr_o, 64'd0);
    chk("rst_mid_discard", mem_rdata, 64'h11);
    step(1'b1, 1'b0, 1'b0, A00, A10, 64'd0);
    step(1'b1, 1'b1, 1'b0, A00, A10, 64'd0);
    chk("rst_mid_not_late", mem_rdata, 64'h11);

    // Both addresses out of range: write address captured
    step(1'b1, 1'b1, 1'b1, 64'h7FFF_FFF0, 64'h9000_0000, 64'd0);
    step(1'b1, 1'b0, 1'b0, A10, A10, 64'd0);
    chk("both_err", {63'd0, err_o}, 64'd1);
    chk("both_err_addr", err_addr_o, 64'h9000_0000);

`ifdef DMEM_STATS_EN
    step(1'b0, 1'b0, 1'b0, A10, A10, 64'd0);
    step(1'b1, 1'b1, 1'b0, A10, A10, 64'd0);
    chk("stats_rst_rd", {32'd0, rd_cnt_o}, 64'd0);
    chk("stats_rst_wr", {32'd0, wr_cnt_o}, 64'd0);
    step(1'b1, 1'b1, 1'b0, A08, A10, 64'd0);
    step(1'b1, 1'b1, 1'b0, A20, A10, 64'd0);
    step(1'b1, 1'b1, 1'b1, A10, A18, 64'd3);
    step(1'b1, 1'b1, 1'b1, A10, A18, 64'd4);
    step(1'b1, 1'b1, 1'b0, ALOW, A10, 64'd0);
    step(1'b1, 1'b0, 1'b0, A10, A10, 64'd0);
    chk("stats_rd", {32'd0, rd_cnt_o}, 64'd3);
    chk("stats_wr", {32'd0, wr_cnt_o}, 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
